mux_scan_ctrl: RTL and testbench
================================

Name: mux_scan_ctrl

Overview:
- Sequential scan controller placed directly upstream and downstream of the 4:1 mux.
- Drives the mux select `sel` through channels 0..NUM_CH-1 and waits a programmable settle time on each channel.
- Samples the mux output `y_in` once per channel and assembles the samples into a parallel word.
- Start/busy/done handshake; supports single-shot and continuous scanning.

Parameters:
- NUM_CH, 4: number of mux channels scanned; must be a power of 2, ≥2.
- SEL_W, 2: select width; must equal log2(NUM_CH).
- SETTLE_CYC, 2: cycles `sel` is held before sampling; legal range 1..15.
- CNT_W, 4: settle-counter width; must satisfy 2^CNT_W > SETTLE_CYC.

Ports:
- clk, input, 1: rising-edge clock; single clock domain.
- rst, input, 1: synchronous, active-high reset.
- start, input, 1: scan request; sampled only in IDLE.
- cont, input, 1: continuous mode; sampled in DONE.
- y_in, input, 1: mux output.
- sel, output, SEL_W: mux select, registered.
- busy, output, 1: high in every state except IDLE.
- done, output, 1: one-cycle pulse when `word` is updated.
- word, output, NUM_CH: last completed scan; bit i = sample of channel i.
- parity, output, 1: present only with SCAN_PARITY_EN.

Behaviour:
- Reset:
  - Synchronous, active-high, single clock `clk`. Reset is sampled at the rising edge of `clk`.
  - While rst=1 at an edge: state=IDLE, sel=0, busy=0, done=0, word=0, shadow=0, cnt=0, parity=0.
  - rst has priority over all other inputs.
  - Reset mid-scan discards the partial shadow; `word` is cleared and no done pulse is issued.
- States: IDLE, SETTLE, SAMPLE, DONE.
- IDLE:
  - If start=1 at an edge: go to SETTLE, sel=0, cnt=0, shadow=0.
  - Otherwise hold all outputs; `word` keeps its last value.
- SETTLE:
  - cnt increments each cycle.
  - When cnt==SETTLE_CYC-1 at an edge: go to SAMPLE.
  - `sel` is stable throughout.
- SAMPLE (exactly 1 cycle):
  - At the edge, shadow[sel] <= y_in.
  - If sel != NUM_CH-1: sel <= sel+1, cnt <= 0, go to SETTLE.
  - If sel == NUM_CH-1:
    - word <= shadow with bit NUM_CH-1 replaced by y_in;
    - done <= 1, sel <= 0;
    - go to DONE.
- DONE (exactly 1 cycle, done=1):
  - At the edge, done <= 0.
  - If cont=1: cnt <= 0, shadow <= 0, go to SETTLE (sel already 0).
  - If cont=0: go to IDLE.
- Latency:
  - From the start-accept edge to the edge raising done: NUM_CH*(SETTLE_CYC+1) cycles. Default: 12.
  - Continuous-mode done period: NUM_CH*(SETTLE_CYC+1)+1 cycles. Default: 13.
- Handshake and boundary conditions:
  - start while busy=1 is ignored; it is not queued.
  - start held high continuously with cont=0: a new scan starts on the first edge after returning to IDLE, i.e. one idle cycle between scans.
  - cont is checked only in DONE. Dropping cont mid-scan lets the current scan finish and then return to IDLE.
  - sel wrap-around: sel never increments past NUM_CH-1; it is explicitly reloaded to 0.
  - `word` changes only on the edge that raises done, so it is stable for a full scan period.
  - `y_in` is sampled only in SAMPLE; changes on `y_in` during SETTLE have no effect.

Optional Feature:
- Macro: SCAN_PARITY_EN.
- Defined:
  - Output port `parity` exists.
  - parity <= XOR of the new word value, registered on the same edge as `word`.
  - Reset value 0.
- Undefined:
  - No `parity` port and no parity logic.
  - All other behaviour is identical.

Test Plan:
- Reset: assert rst for 2 cycles mid-scan (sel=2) -> next cycle: sel=0, busy=0, done=0, word=0; no done pulse follows.
- Single scan: mux data in=4'b1010, one-cycle start pulse, cont=0 -> sel steps 0,1,2,3, each held 3 cycles; done pulses 12 cycles after the start edge; word=4'b1010; busy drops 1 cycle later.
- Busy rejection: during a scan, pulse start at sel=1 -> no restart, done is still at cycle 12, and exactly one done pulse occurs.
- Continuous mode: cont=1, in=4'b0110, then in=4'b1001 after the first done -> done pulses exactly 13 cycles apart; word=4'b0110 then 4'b1001; drop cont mid-second-scan -> second scan completes, then IDLE.
- Settle isolation: toggle y_in during SETTLE, stable during SAMPLE -> word reflects only the SAMPLE-cycle values.
- Parity (SCAN_PARITY_EN defined): word=4'b1011 -> parity=1; word=4'b0110 -> parity=0. With the macro undefined, the design elaborates with no parity port.

Source files
------------

// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl: sequential scan controller around a NUM_CH:1 mux.
// Steps the mux select through every channel, holds each channel for
// SETTLE_CYC cycles, samples y_in once per channel and publishes the
// assembled word with a one-cycle done pulse. Single-shot or continuous.
// Optional feature macro: SCAN_PARITY_EN adds a registered even-parity
// output `parity` covering `word`.
module mux_scan_ctrl #(
  parameter int NUM_CH     = 4,
  parameter int SEL_W      = 2,
  parameter int SETTLE_CYC = 2,
  parameter int CNT_W      = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              cont,
  input  logic              y_in,
  output logic [SEL_W-1:0]  sel,
  output logic              busy,
  output logic              done,
  output logic [NUM_CH-1:0] word
`ifdef SCAN_PARITY_EN
  ,
  output logic              parity
`endif
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(NUM_CH - 1);
  localparam logic [SEL_W-1:0] SEL_ONE  = SEL_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t            state;
  state_t            state_nxt;
  logic [SEL_W-1:0]  sel_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_nxt;
  logic [NUM_CH-1:0] shadow;
  logic [NUM_CH-1:0] shadow_nxt;
  logic [NUM_CH-1:0] word_nxt;
  logic              done_nxt;
  logic              busy_nxt;

`ifdef SCAN_PARITY_EN
  logic              parity_nxt;

  // Even parity over a sample word (1 when an odd number of bits are set).
  function automatic logic calc_parity(input logic [NUM_CH-1:0] v);
    return ^v;
  endfunction
`endif

  // Next-state and next-output logic for the scan sequencer.
  always_comb begin
    state_nxt  = state;
    sel_nxt    = sel;
    cnt_nxt    = cnt;
    shadow_nxt = shadow;
    word_nxt   = word;
    done_nxt   = 1'b0;
`ifdef SCAN_PARITY_EN
    parity_nxt = parity;
`endif
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt  = SETTLE;
          sel_nxt    = '0;
          cnt_nxt    = '0;
          shadow_nxt = '0;
        end else begin
          state_nxt  = IDLE;
        end
      end
      SETTLE: begin
        // sel is held; the counter only times the settle window.
        cnt_nxt = cnt + CNT_ONE;
        if (cnt == CNT_LAST) begin
          state_nxt = SAMPLE;
        end else begin
          state_nxt = SETTLE;
        end
      end
      SAMPLE: begin
        // The only place y_in is captured.
        shadow_nxt[sel] = y_in;
        if (sel != SEL_LAST) begin
          sel_nxt   = sel + SEL_ONE;
          cnt_nxt   = '0;
          state_nxt = SETTLE;
        end else begin
          // shadow_nxt already carries the last channel's sample.
          word_nxt  = shadow_nxt;
          done_nxt  = 1'b1;
          sel_nxt   = '0;
          state_nxt = DONE;
`ifdef SCAN_PARITY_EN
          parity_nxt = calc_parity(shadow_nxt);
`endif
        end
      end
      DONE: begin
        if (cont) begin
          cnt_nxt    = '0;
          shadow_nxt = '0;
          state_nxt  = SETTLE;
        end else begin
          state_nxt  = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
    // busy is registered alongside state so it tracks it exactly.
    busy_nxt = (state_nxt != IDLE);
  end

  // State and output registers; reset discards any partial scan.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      sel    <= '0;
      cnt    <= '0;
      shadow <= '0;
      word   <= '0;
      done   <= 1'b0;
      busy   <= 1'b0;
`ifdef SCAN_PARITY_EN
      parity <= 1'b0;
`endif
    end else begin
      state  <= state_nxt;
      sel    <= sel_nxt;
      cnt    <= cnt_nxt;
      shadow <= shadow_nxt;
      word   <= word_nxt;
      done   <= done_nxt;
      busy   <= busy_nxt;
`ifdef SCAN_PARITY_EN
      parity <= parity_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Scoreboard bench for mux_scan_ctrl (default parameters: 4 channels,
// settle 2). A behavioural 4:1 mux drives y_in from mux_in[sel]; every
// scan request pushes the expected word and the cycle its done pulse
// is due, and a done monitor pops and compares.
module tb_mux_scan_ctrl;

  logic       clk;
  logic       rst;
  logic       start;
  logic       cont;
  logic       y_in;
  logic [1:0] sel;
  logic       busy;
  logic       done;
  logic [3:0] word;
`ifdef SCAN_PARITY_EN
  logic       parity;
`endif

  logic [3:0] mux_in;
  logic       noise_en;
  int         cyc;
  int         n_checks;
  int         n_fail;

  typedef struct {
    logic [3:0] w;
    int         due;
  } exp_t;

  exp_t sb[$];

  mux_scan_ctrl dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .cont  (cont),
    .y_in  (y_in),
    .sel   (sel),
    .busy  (busy),
    .done  (done),
    .word  (word)
`ifdef SCAN_PARITY_EN
    ,
    .parity(parity)
`endif
  );

  // Mux model; noise inverts the output while a channel is settling.
  assign y_in = mux_in[sel] ^ noise_en;

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Edge counter used to timestamp done pulses.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Done monitor: every done pulse must match the oldest scoreboard entry.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && done === 1'b1) begin
      if (sb.size() == 0) begin
        check("spurious_done", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check("word", {28'd0, word}, {28'd0, e.w});
        check("done_cycle", cyc, e.due);
`ifdef SCAN_PARITY_EN
        check("parity", {31'd0, parity}, {31'd0, ^e.w});
`endif
      end
    end
  end

  // One single-shot scan; optional start pulse at scan cycle rej_k and
  // optional inversion of y_in during every SETTLE cycle.
  task automatic run_scan(input logic [3:0] data, input int rej_k, input bit noisy);
    exp_t e;
    mux_in = data;
    start  = 1'b1;
    e.w    = data;
    e.due  = cyc + 13;
    sb.push_back(e);
    for (int k = 0; k <= 13; k++) begin
      @(negedge clk);
      start    = (k == rej_k);
      noise_en = noisy && (k < 12) && ((k % 3) != 2);
      if (k <= 12) begin
        check("sel_step", {30'd0, sel}, (k % 12) / 3);
        check("busy", {31'd0, busy}, 32'd1);
      end else begin
        check("busy_drop", {31'd0, busy}, 32'd0);
      end
    end
    start    = 1'b0;
    noise_en = 1'b0;
    check("sb_drained", sb.size(), 32'd0);
  endtask

  initial begin
    exp_t e;
    int   c;
    bit   seen;
    n_checks = 0;
    n_fail   = 0;
    cyc      = 0;
    rst      = 1'b1;
    start    = 1'b0;
    cont     = 1'b0;
    mux_in   = 4'd0;
    noise_en = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_sel", {30'd0, sel}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_word", {28'd0, word}, 32'd0);
`ifdef SCAN_PARITY_EN
    check("rst_parity", {31'd0, parity}, 32'd0);
`endif
    rst = 1'b0;
    @(negedge clk);

    // Single scan, then one with a start pulse at sel=1 (must be ignored).
    run_scan(4'b1010, -1, 1'b0);
    repeat (2) @(negedge clk);
    check("word_hold", {28'd0, word}, 32'd10);
    run_scan(4'b1011, 4, 1'b0);
    repeat (2) @(negedge clk);
    // Settle isolation: y_in inverted in every SETTLE cycle.
    run_scan(4'b0011, -1, 1'b1);
    repeat (2) @(negedge clk);

    // Continuous mode, data changes after first done, cont dropped mid-scan.
    mux_in = 4'b0110;
    cont   = 1'b1;
    start  = 1'b1;
    c      = cyc;
    e.w = 4'b0110; e.due = c + 13; sb.push_back(e);
    e.w = 4'b1001; e.due = c + 26; sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    repeat (12) @(negedge clk);
    mux_in = 4'b1001;
    repeat (7) @(negedge clk);
    cont = 1'b0;
    repeat (7) @(negedge clk);
    check("cont_idle", {31'd0, busy}, 32'd0);
    repeat (15) @(negedge clk);
    check("cont_drained", sb.size(), 32'd0);

    // start held high: one idle cycle between back-to-back scans.
    mux_in = 4'b0101;
    start  = 1'b1;
    c      = cyc;
    e.w = 4'b0101; e.due = c + 13; sb.push_back(e);
    e.w = 4'b0101; e.due = c + 27; sb.push_back(e);
    repeat (20) @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    check("held_idle", {31'd0, busy}, 32'd0);
    check("held_drained", sb.size(), 32'd0);

    // Reset mid-scan at sel=2: partial scan discarded, no done pulse.
    mux_in = 4'b1111;
    start  = 1'b1;
    e.w = 4'b1111; e.due = cyc + 13; sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    seen  = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (sel == 2'd2) seen = 1'b1;
    end
    check("reach_sel2", {31'd0, seen}, 32'd1);
    rst = 1'b1;
    sb.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_sel", {30'd0, sel}, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_done", {31'd0, done}, 32'd0);
    check("mid_rst_word", {28'd0, word}, 32'd0);
    repeat (20) @(negedge clk);
    check("post_rst_word", {28'd0, word}, 32'd0);
    check("post_rst_busy", {31'd0, busy}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
